// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA raster timing generator.
// A pixel-rate enable is derived from the system clock rather than a second clock.
// All outputs are registered and move together on pixel-advance edges.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             h_wrap;
  logic             v_wrap;

  assign tick = (div_cnt == DIV_LAST);

  // Clock divider: counts 0..CLK_DIV-1, the last count triggers a pixel advance.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Next raster position; only consumed on tick edges.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    h_nxt  = h_cnt + 10'd1;
    v_nxt  = v_cnt;
    h_wrap = 1'b0;
    v_wrap = 1'b0;
    if (h_cnt == H_LAST) begin
      h_nxt  = '0;
      h_wrap = 1'b1;
      if (v_cnt == V_LAST) begin
        v_nxt  = '0;
        v_wrap = 1'b1;
      end else begin
        v_nxt = v_cnt + 10'd1;
      end
    end
  end

  // Output registers: counters, decodes and markers all update on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_en      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      valid       <= 1'b1;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= tick;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        valid       <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
        hsync       <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
        vsync       <= !((v_nxt >= VS_START) && (v_nxt < VS_END));
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Full horizontal timing; the vertical
// dimension is shortened so several whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int CLK_DIV  = 4;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LINE_CLKS  = HT * CLK_DIV;
  localparam int FRAME_CLKS = HT * VT * CLK_DIV;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       valid;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_en, valid, hsync, vsync, line_start, frame_start;
  logic [9:0] h_cnt, v_cnt;
  obs_t       dut_obs;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .valid(valid), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
  );

  assign dut_obs = {pix_en, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference: after k non-reset edges the raster sits at pixel floor(k/CLK_DIV).
  function automatic obs_t model(input int k);
    obs_t o;
    int p, h, v;
    p = k / CLK_DIV;
    h = p % HT;
    v = (p / HT) % VT;
    o.pix_en = (k > 0) && (k % CLK_DIV == 0);
    o.h      = 10'(h);
    o.v      = 10'(v);
    o.valid  = (h < H_ACTIVE) && (v < V_ACTIVE);
    o.hs     = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
    o.vs     = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
    o.ls     = o.pix_en && (h == 0);
    o.fs     = o.ls && (v == 0);
    return o;
  endfunction

  obs_t sb_q[$];
  int   k = 0;
  int   hs_low = 0;
  int   vs_low = 0;
  int   first_pe = -1;
  int   fs_q[$];

  // Stimulus side: track edges since reset release and push the expected outputs.
  initial forever begin
    @(posedge clk);
    if (!rst) k = 0;
    else      k++;
    sb_q.push_back(model(k));
  end

  // Output side: pop and compare every cycle, plus gather interval statistics.
  initial forever begin
    obs_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("cyc", 32'(dut_obs), 32'(e));
    end
    if (rst && k >= 1 && k <= LINE_CLKS && !hsync) hs_low++;
    if (rst && k > FRAME_CLKS && k <= 2 * FRAME_CLKS && !vsync) vs_low++;
    if (rst && pix_en && first_pe < 0) first_pe = k;
    if (rst && frame_start) fs_q.push_back(k);
  end

  task automatic run_until(input int goal, input string tag);
    for (int n = 0; n < 3 * FRAME_CLKS && k < goal; n++) @(negedge clk);
    check(tag, 32'(k), 32'(goal));
  endtask

  initial begin
    obs_t rst_obs;
    rst_obs = model(0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dut_obs), 32'(rst_obs));
    rst = 1'b1;

    run_until(2 * FRAME_CLKS, "reach_frame2");
    check("first_pe_clk", 32'(first_pe), 32'(CLK_DIV));
    check("hsync_low_clks", 32'(hs_low), 32'(H_SYNC * CLK_DIV));
    check("vsync_low_clks", 32'(vs_low), 32'(V_SYNC * LINE_CLKS));
    check("fs_count", 32'(fs_q.size()), 32'd2);
    if (fs_q.size() == 2) begin
      check("fs_first", 32'(fs_q[0]), 32'(FRAME_CLKS));
      check("fs_period", 32'(fs_q[1] - fs_q[0]), 32'(FRAME_CLKS));
    end

    // Mid-frame reset with the raster at line 2, column 300, div_cnt == 2.
    run_until(2 * FRAME_CLKS + (2 * HT + 300) * CLK_DIV + 2, "reach_mid");
    check("pre_rst_h", 32'(h_cnt), 32'd300);
    check("pre_rst_v", 32'(v_cnt), 32'd2);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 32'(dut_obs), 32'(rst_obs));
    check("mid_rst_no_fs", 32'(frame_start), 32'd0);
    rst = 1'b1;
    repeat (LINE_CLKS + 400) @(negedge clk);
    check("resume_h", 32'(h_cnt), 32'((((LINE_CLKS + 400) / CLK_DIV)) % HT));
    check("resume_v", 32'(v_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a wait above ever stalls.
  initial begin
    #(10 * 100000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60Hz VGA raster timing for the display path from the 100 MHz system clock. It uses an internal pixel-rate enable, not a separate derived clock. It supplies the sync, active-video flag, pixel coordinates and frame/line markers that the display top level and its object layers (mouse, card, button, background) consume. All outputs are registered and change together on pixel-enable cycles.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); must be >= 2
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = 800
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk
pix_en  output  1  one-clk pulse every CLK_DIV clocks; marks a pixel boundary
h_cnt  output  10  current pixel column, 0..H_TOTAL-1
v_cnt  output  10  current line, 0..V_TOTAL-1
valid  output  1  1 when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
hsync  output  1  horizontal sync, active-low
vsync  output  1  vertical sync, active-low
line_start  output  1  one-clk pulse on the clk where h_cnt becomes 0
frame_start  output  1  one-clk pulse on the clk where (h_cnt, v_cnt) becomes (0,0)

Behaviour:
- Reset (rst==0 at a clk edge): div_cnt=0, h_cnt=0, v_cnt=0, pix_en=0, line_start=0, frame_start=0, hsync=1, vsync=1, valid=1. These are the values for pixel (0,0).
- Reset has priority over all other updates. Reset asserted mid-frame returns to (0,0) on the next edge with no partial line or sync glitch.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en is registered and is 1 for the single clk after div_cnt was CLK_DIV-1.
- First pix_en after reset release occurs CLK_DIV clocks after the first non-reset edge. The period is exactly CLK_DIV clocks thereafter.
- Counter advance: on the edge where div_cnt==CLK_DIV-1, the next state is computed and registered. pix_en, h_cnt, v_cnt, valid, hsync, vsync, line_start and frame_start all update on that same edge, so they are mutually consistent in every cycle.
- Horizontal: if h_cnt==H_TOTAL-1, then h_cnt->0 and line_start=1; else h_cnt+1.
- Vertical: v_cnt advances only when h wraps. If v_cnt==V_TOTAL-1, then v_cnt->0; else v_cnt+1.
- frame_start=1 when both counters wrap on the same advance.
- line_start and frame_start are 0 on all other clocks; each is one clk wide.
- Sync decode, applied to the new counter values:
  - hsync=0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. columns 656..751.
  - vsync=0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491.
  - vsync changes only at h_cnt==0.
- valid is decoded from the new counter values. Downstream layers must output black when valid==0.
- Arithmetic: all comparisons unsigned at 10-bit width. H_TOTAL and V_TOTAL must be <= 1024. No other state.
- Between pix_en pulses, all outputs except pix_en hold their values.

Test Plan:
- Reset then release: hold rst=0 for 3 clk, then rst=1. Required: h=v=0, valid=1, hsync=vsync=1; first pix_en on clk 4 after release, then every 4 clk; h_cnt=1 on the first pix_en.
- Active edge: run to h_cnt=639 then the next pix_en. Required: h_cnt=640 and valid 1->0 on the same clk; valid returns to 1 at h_cnt=0 on lines <480.
- HSYNC window: scan one line. Required: hsync=0 exactly for h_cnt 656..751, i.e. 96 pixels = 384 clk; 1 elsewhere.
- Line/frame wrap: at h=799, v=524, next pix_en. Required: h=0, v=0, line_start=1 and frame_start=1 for one clk; vsync=0 only on lines 490..491. Consecutive frame_start pulses are exactly 800*525*4 = 1,680,000 clk apart.
- Reset mid-frame: assert rst=0 at h=300, v=200 with div_cnt=2. Required: next edge gives h=v=0, valid=1, hsync=vsync=1, pix_en=0, no frame_start pulse; normal timing resumes after release.
